// File: rtl/msrv32_pkg.sv
// Shared opcode, funct3 and 2-bit counter encodings for the msrv32 branch logic.
package msrv32_pkg;

  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/msrv32_bu_cmp.sv
// Combinational branch direction decoder: opcode/funct3 plus operands -> taken.
module msrv32_bu_cmp
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1_s = $signed(rs1);
  assign rs2_s = $signed(rs2);

  // Jumps are always taken; conditional branches compare; illegal funct3 and other opcodes fall through
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPCODE_JAL, OPCODE_JALR: taken = 1'b1;
      OPCODE_BRANCH: begin
        case (funct3)
          FUNCT3_BEQ:  taken = (rs1 == rs2);
          FUNCT3_BNE:  taken = (rs1 != rs2);
          FUNCT3_BLT:  taken = (rs1_s < rs2_s);
          FUNCT3_BGE:  taken = (rs1_s >= rs2_s);
          FUNCT3_BLTU: taken = (rs1 < rs2);
          FUNCT3_BGEU: taken = (rs1 >= rs2);
          default:     taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/msrv32_bpu.sv
// Branch prediction/resolution unit: direct-mapped 2-bit counter table with
// one-cycle registered lookup, registered resolve, training and mispredict statistics.
module msrv32_bpu
  import msrv32_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            pred_valid_in,
  input  logic [XLEN-1:0] pred_pc_in,
  output logic            pred_valid_out,
  output logic            pred_taken_out,
  input  logic            res_valid_in,
  input  logic [XLEN-1:0] res_pc_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            res_pred_taken_in,
  output logic            res_valid_out,
  output logic            branch_taken_out,
  output logic            mispredict_out,
  output logic [31:0]     mispredict_count_out
);

  localparam int IDX = $clog2(BHT_DEPTH);

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] pred_idx;
  logic [IDX-1:0] res_idx;
  logic           res_taken;
  logic           res_mispred;
  logic           res_train;

  logic           pred_vld_p1;
  logic           pred_taken_p1;
  logic           res_vld_p1;
  logic           br_taken_p1;
  logic           mispred_p1;
  logic [31:0]    mispred_cnt_p1;

  // PC bits outside the index field carry no information for the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_in[XLEN-1:IDX+2], pred_pc_in[1:0],
                            res_pc_in[XLEN-1:IDX+2], res_pc_in[1:0]};

  function automatic logic [1:0] ctr_sat_step(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  assign pred_idx    = pred_pc_in[IDX+1:2];
  assign res_idx     = res_pc_in[IDX+1:2];
  assign res_train   = res_valid_in && (opcode_6_to_2_in == OPCODE_BRANCH);
  assign res_mispred = res_valid_in && (res_taken != res_pred_taken_in);

  msrv32_bu_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .opcode(opcode_6_to_2_in),
    .funct3(funct3_in),
    .rs1   (rs1_in),
    .rs2   (rs2_in),
    .taken (res_taken)
  );

  // Counter table: reset to CTR_INIT, trained only by conditional branches
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (res_train) begin
      bht[res_idx] <= ctr_sat_step(bht[res_idx], res_taken);
    end
  end

  // Lookup stage: reads the pre-update counter, so same-cycle training is not visible yet
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      pred_vld_p1   <= 1'b0;
      pred_taken_p1 <= 1'b0;
    end else begin
      pred_vld_p1   <= pred_valid_in;
      pred_taken_p1 <= pred_valid_in && bht[pred_idx][1];
    end
  end

  // Resolve stage: direction, mispredict flag and saturating statistic
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      res_vld_p1     <= 1'b0;
      br_taken_p1    <= 1'b0;
      mispred_p1     <= 1'b0;
      mispred_cnt_p1 <= 32'd0;
    end else begin
      res_vld_p1  <= res_valid_in;
      br_taken_p1 <= res_valid_in && res_taken;
      mispred_p1  <= res_mispred;
      if (res_mispred) mispred_cnt_p1 <= cnt_sat_inc(mispred_cnt_p1);
    end
  end

  assign pred_valid_out       = pred_vld_p1;
  assign pred_taken_out       = pred_taken_p1;
  assign res_valid_out        = res_vld_p1;
  assign branch_taken_out     = br_taken_p1;
  assign mispredict_out       = mispred_p1;
  assign mispredict_count_out = mispred_cnt_p1;

endmodule

// File: tb/tb_msrv32_bpu.sv
// Bench for msrv32_bpu: a 32-bit/64-entry and a 64-bit/2-entry instance driven in lock-step,
// both checked every cycle against a counter-table model.
module tb_msrv32_bpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pv = 1'b0;
  logic        rv = 1'b0;
  logic        rpt = 1'b0;
  logic [4:0]  op = '0;
  logic [2:0]  f3 = '0;
  logic [63:0] ppc = '0;
  logic [63:0] rpc = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;

  logic        a_pv, a_pt, a_rv, a_bt, a_mp;
  logic [31:0] a_cnt;
  logic        b_pv, b_pt, b_rv, b_bt, b_mp;
  logic [31:0] b_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int          step_no = 0;

  int          ctr_a [64];
  int          ctr_b [2];
  longint      cnt_a, cnt_b;

  always #5 clk = ~clk;

  msrv32_bpu #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) u_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .pred_valid_in(pv), .pred_pc_in(ppc[31:0]),
    .pred_valid_out(a_pv), .pred_taken_out(a_pt),
    .res_valid_in(rv), .res_pc_in(rpc[31:0]),
    .opcode_6_to_2_in(op), .funct3_in(f3),
    .rs1_in(rs1[31:0]), .rs2_in(rs2[31:0]),
    .res_pred_taken_in(rpt),
    .res_valid_out(a_rv), .branch_taken_out(a_bt),
    .mispredict_out(a_mp), .mispredict_count_out(a_cnt)
  );

  msrv32_bpu #(.XLEN(64), .BHT_DEPTH(2), .CTR_INIT(2'b01)) u_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .pred_valid_in(pv), .pred_pc_in(ppc),
    .pred_valid_out(b_pv), .pred_taken_out(b_pt),
    .res_valid_in(rv), .res_pc_in(rpc),
    .opcode_6_to_2_in(op), .funct3_in(f3),
    .rs1_in(rs1), .rs2_in(rs2),
    .res_pred_taken_in(rpt),
    .res_valid_out(b_rv), .branch_taken_out(b_bt),
    .mispredict_out(b_mp), .mispredict_count_out(b_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  // Direction from the ISA rules; signed order obtained by flipping the sign bit (offset binary)
  function automatic bit ref_dir(input logic [4:0] o, input logic [2:0] f,
                                 input logic [63:0] a, input logic [63:0] b, input int xlen);
    logic [63:0] msb;
    logic [63:0] sa;
    logic [63:0] sb;
    msb = 64'd1 << (xlen - 1);
    sa  = a ^ msb;
    sb  = b ^ msb;
    if (o == 5'b11011 || o == 5'b11001) return 1'b1;
    if (o != 5'b11000) return 1'b0;
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int train(input int c, input bit up);
    if (up) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // One clock: drive inputs, predict both instances, advance the model, check after the edge
  task automatic step(input bit r, input bit pv_i, input logic [63:0] ppc_i,
                      input bit rv_i, input logic [63:0] rpc_i, input logic [4:0] op_i,
                      input logic [2:0] f3_i, input logic [63:0] rs1_i, input logic [63:0] rs2_i,
                      input bit rpt_i);
    bit da, db;
    bit ea_pv, ea_pt, ea_rv, ea_bt, ea_mp;
    bit eb_pv, eb_pt, eb_rv, eb_bt, eb_mp;
    int pia, pib, ria, rib;
    rst = r; pv = pv_i; ppc = ppc_i; rv = rv_i; rpc = rpc_i;
    op = op_i; f3 = f3_i; rs1 = rs1_i; rs2 = rs2_i; rpt = rpt_i;
    da  = ref_dir(op_i, f3_i, {32'd0, rs1_i[31:0]}, {32'd0, rs2_i[31:0]}, 32);
    db  = ref_dir(op_i, f3_i, rs1_i, rs2_i, 64);
    pia = int'(ppc_i[7:2]);
    pib = int'(ppc_i[2]);
    ria = int'(rpc_i[7:2]);
    rib = int'(rpc_i[2]);
    ea_pv = pv_i && !r;  ea_pt = ea_pv && (ctr_a[pia] >= 2);
    eb_pv = pv_i && !r;  eb_pt = eb_pv && (ctr_b[pib] >= 2);
    ea_rv = rv_i && !r;  ea_bt = ea_rv && da;  ea_mp = ea_rv && (da != rpt_i);
    eb_rv = rv_i && !r;  eb_bt = eb_rv && db;  eb_mp = eb_rv && (db != rpt_i);
    if (r) begin
      foreach (ctr_a[i]) ctr_a[i] = 1;
      foreach (ctr_b[i]) ctr_b[i] = 1;
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (rv_i && op_i == 5'b11000) begin
        ctr_a[ria] = train(ctr_a[ria], da);
        ctr_b[rib] = train(ctr_b[rib], db);
      end
      if (ea_mp && cnt_a < 64'hFFFF_FFFF) cnt_a++;
      if (eb_mp && cnt_b < 64'hFFFF_FFFF) cnt_b++;
    end
    @(posedge clk);
    @(negedge clk);
    step_no++;
    chk("a_pred_valid", a_pv, ea_pv);
    chk("a_pred_taken", a_pt, ea_pt);
    chk("a_res_valid", a_rv, ea_rv);
    chk("a_branch_taken", a_bt, ea_bt);
    chk("a_mispredict", a_mp, ea_mp);
    chk("a_count", a_cnt, cnt_a);
    chk("b_pred_valid", b_pv, eb_pv);
    chk("b_pred_taken", b_pt, eb_pt);
    chk("b_res_valid", b_rv, eb_rv);
    chk("b_branch_taken", b_bt, eb_bt);
    chk("b_mispredict", b_mp, eb_mp);
    chk("b_count", b_cnt, cnt_b);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, 3'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic lookup(input logic [63:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 64'd0, 5'd0, 3'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic resolve(input logic [63:0] pc, input logic [4:0] o, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b, input bit p);
    step(1'b0, 1'b0, 64'd0, 1'b1, pc, o, f, a, b, p);
  endtask

  task automatic sweep_all();
    for (int i = 0; i < 64; i++) begin
      lookup(64'(i * 4));
      chk("sweep_init", a_pt, 1'b0);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    bit          rpt;
    bit          exp_taken;
  } vec_t;

  vec_t vt [14];

  initial begin
    vt[0]  = '{"blt_neg",    5'b11000, 3'b100, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1};
    vt[1]  = '{"bltu_big",   5'b11000, 3'b110, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0};
    vt[2]  = '{"bge_eq",     5'b11000, 3'b101, 64'd7, 64'd7, 1'b1, 1'b1};
    vt[3]  = '{"bgeu_eq",    5'b11000, 3'b111, 64'd7, 64'd7, 1'b0, 1'b1};
    vt[4]  = '{"f3_010",     5'b11000, 3'b010, 64'd3, 64'd3, 1'b1, 1'b0};
    vt[5]  = '{"f3_011",     5'b11000, 3'b011, 64'd3, 64'd9, 1'b0, 1'b0};
    vt[6]  = '{"bne_diff",   5'b11000, 3'b001, 64'd1, 64'd2, 1'b1, 1'b1};
    vt[7]  = '{"beq_diff",   5'b11000, 3'b000, 64'd1, 64'd2, 1'b1, 1'b0};
    vt[8]  = '{"jal",        5'b11011, 3'b101, 64'd1, 64'd2, 1'b0, 1'b1};
    vt[9]  = '{"jalr",       5'b11001, 3'b000, 64'd5, 64'd5, 1'b0, 1'b1};
    vt[10] = '{"op_01100",   5'b01100, 3'b000, 64'd5, 64'd5, 1'b0, 1'b0};
    vt[11] = '{"bge_minint", 5'b11000, 3'b101, 64'h8000_0000, 64'd0, 1'b0, 1'b0};
    vt[12] = '{"bgeu_msb",   5'b11000, 3'b111, 64'h8000_0000, 64'd0, 1'b0, 1'b1};
    vt[13] = '{"bltu_small", 5'b11000, 3'b110, 64'd0, 64'd1, 1'b1, 1'b1};

    @(negedge clk);
    do_reset();
    lookup(64'h100);
    chk("init_lookup_valid", a_pv, 1'b1);
    chk("init_lookup_taken", a_pt, 1'b0);
    sweep_all();

    // Three taken BEQs drive counter 01 -> 11, then saturation
    for (int i = 0; i < 3; i++) begin
      resolve(64'h100, 5'b11000, 3'b000, 64'd1, 64'd1, 1'b0);
      chk("beq_taken", a_bt, 1'b1);
      chk("beq_mispredict", a_mp, 1'b1);
    end
    chk("beq_count3", a_cnt, 32'd3);
    lookup(64'h100);
    chk("beq_lookup_taken", a_pt, 1'b1);
    resolve(64'h100, 5'b11000, 3'b000, 64'd1, 64'd1, 1'b1);
    chk("beq_sat_no_mispredict", a_mp, 1'b0);
    resolve(64'h100, 5'b11000, 3'b000, 64'd1, 64'd2, 1'b1);
    lookup(64'h100);
    chk("beq_sat_one_down", a_pt, 1'b1);

    // Direction table
    for (int i = 0; i < 14; i++) begin
      resolve(64'h200 + 64'(i * 4), vt[i].op, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].rpt);
      chk({"vec_taken_", vt[i].name}, a_bt, vt[i].exp_taken);
      chk({"vec_mispredict_", vt[i].name}, a_mp, vt[i].exp_taken != vt[i].rpt);
    end
    for (int i = 0; i < 64; i++) lookup(64'(i * 4));

    // Same-cycle read/train of index 5, then aliased PC sees the update
    do_reset();
    step(1'b0, 1'b1, 64'h14, 1'b1, 64'h14, 5'b11000, 3'b000, 64'd1, 64'd1, 1'b0);
    chk("rbw_old_value", a_pt, 1'b0);
    lookup(64'h114);
    chk("rbw_alias_new_value", a_pt, 1'b1);

    // Reset with requests pending
    resolve(64'h20, 5'b11000, 3'b000, 64'd0, 64'd0, 1'b0);
    resolve(64'h20, 5'b11000, 3'b000, 64'd0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 64'h20, 1'b1, 64'h20, 5'b11011, 3'b000, 64'd0, 64'd0, 1'b0);
    chk("rst_pred_valid", a_pv, 1'b0);
    chk("rst_res_valid", a_rv, 1'b0);
    chk("rst_count", a_cnt, 32'd0);
    chk("rst_count_b", b_cnt, 32'd0);
    sweep_all();

    // Randomized traffic, both channels every cycle
    for (int n = 0; n < 400; n++) begin
      bit          r;
      int          sel;
      logic [4:0]  o;
      logic [63:0] a, b, pa, pb;
      r   = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 9);
      o   = (sel < 7) ? 5'b11000 : (sel == 7) ? 5'b11011 : (sel == 8) ? 5'b11001 : 5'($urandom);
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[31] = ~a[31];
      pa  = {$urandom, 22'($urandom), 10'($urandom_range(0, 15) * 4 + $urandom_range(0, 3))};
      pb  = {$urandom, 22'($urandom), 10'($urandom_range(0, 15) * 4 + $urandom_range(0, 3))};
      step(r, 1'($urandom), pa, 1'($urandom), pb, o, 3'($urandom), a, b, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
